// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: IF stage feeding the IF/ID register over a req/ready imem handshake.
// Define FETCH_PERF_EN to add the fetched-word and stall-cycle counters.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] instructionOut,
    output logic [31:0] PCplus4Out,
    output logic        fetch_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall_cycles
`endif
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;
    state_t state, state_nxt;
    logic [31:0] pc, skid_instr, skid_pc4;
    logic load_ok, take, to_skid, hold_done;
    always_comb begin
        load_ok   = !fetch_valid || !stall;
        take      = state == S_REQ && imem_ready && load_ok;
        to_skid   = state == S_REQ && imem_ready && !load_ok;
        hold_done = state == S_HOLD && !stall;
        imem_req  = state == S_REQ;
        imem_addr = pc;
        state_nxt = redirect || state == S_IDLE || hold_done ? S_REQ :
                    to_skid ? S_HOLD : state;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else state <= state_nxt;
    end
    // A skidded word is delivered only once ID frees up; pc tracks the word in outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc             <= RESET_PC;
            instructionOut <= NOP_INSTR;
            PCplus4Out     <= '0;
            fetch_valid    <= 1'b0;
            skid_instr     <= '0;
            skid_pc4       <= '0;
        end else if (redirect) begin
            pc             <= redirect_target & ~32'd3;
            instructionOut <= NOP_INSTR;
            PCplus4Out     <= '0;
            fetch_valid    <= 1'b0;
        end else if (take) begin
            pc             <= pc + 32'd4;
            instructionOut <= imem_rdata;
            PCplus4Out     <= pc + 32'd4;
            fetch_valid    <= 1'b1;
        end else if (to_skid) begin
            skid_instr     <= imem_rdata;
            skid_pc4       <= pc + 32'd4;
        end else if (hold_done) begin
            pc             <= pc + 32'd4;
            instructionOut <= skid_instr;
            PCplus4Out     <= skid_pc4;
            fetch_valid    <= 1'b1;
        end
    end
`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetched      <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (!redirect && (take || hold_done)) perf_fetched <= perf_fetched + 32'd1;
            if (stall && fetch_valid) perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed stimulus checked against a queue-based fetch-stream model.
module tb_instruction_fetch_unit;
    logic        clk = 1'b0, reset_n = 1'b0, stall = 1'b0, redirect = 1'b0, imem_ready = 1'b1;
    logic [31:0] redirect_target = '0;
    logic        imem_req, fetch_valid, req2, fv2;
    logic [31:0] imem_addr, imem_rdata, instructionOut, PCplus4Out, addr2, rdata2, ins2, p42;
    int checks = 0, errors = 0;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_stall_cycles, pf2, ps2;
`endif

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_2468;
    endfunction

    assign imem_rdata = mem(imem_addr);
    assign rdata2     = mem(addr2);

    instruction_fetch_unit dut (
        .clk(clk), .reset_n(reset_n), .stall(stall), .redirect(redirect),
        .redirect_target(redirect_target), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready), .instructionOut(instructionOut),
        .PCplus4Out(PCplus4Out), .fetch_valid(fetch_valid)
`ifdef FETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_stall_cycles(perf_stall_cycles)
`endif
    );

    instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset_n(reset_n), .stall(1'b0), .redirect(1'b0),
        .redirect_target(32'h0), .imem_req(req2), .imem_addr(addr2),
        .imem_rdata(rdata2), .imem_ready(1'b1), .instructionOut(ins2),
        .PCplus4Out(p42), .fetch_valid(fv2)
`ifdef FETCH_PERF_EN
        , .perf_fetched(pf2), .perf_stall_cycles(ps2)
`endif
    );

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", n, act, exp);
        end
    endtask

    // Model: words fetched but not yet taken by ID wait in a queue; a new request
    // goes out only when nothing is waiting.
    typedef struct {logic [31:0] ins; logic [31:0] a4;} word_t;
    word_t       q[$];
    word_t       w;
    logic        m_boot, m_fv, m_req;
    logic [31:0] m_next, m_ins, m_p4, m_fetched, m_stalls;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q.delete();
            m_boot = 1'b1; m_fv = 1'b0; m_next = 32'h0; m_ins = 32'h0; m_p4 = 32'h0;
            m_fetched = 32'h0; m_stalls = 32'h0;
        end else begin
            m_req = !m_boot && q.size() == 0;
            if (stall && m_fv) m_stalls = m_stalls + 1;
            if (redirect) begin
                q.delete();
                m_fv = 1'b0; m_ins = 32'h0; m_p4 = 32'h0;
                m_next = {redirect_target[31:2], 2'b00};
            end else begin
                if (m_req && imem_ready) begin
                    q.push_back('{mem(m_next), m_next + 32'd4});
                    m_next = m_next + 32'd4;
                end
                if (q.size() > 0 && (!m_fv || !stall)) begin
                    w = q.pop_front();
                    m_ins = w.ins; m_p4 = w.a4; m_fv = 1'b1;
                    m_fetched = m_fetched + 1;
                end
            end
            m_boot = 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("imem_req", {31'b0, imem_req}, {31'b0, !m_boot && q.size() == 0});
        if (imem_req) chk("imem_addr", imem_addr, m_next);
        chk("fetch_valid", {31'b0, fetch_valid}, {31'b0, m_fv});
        chk("instructionOut", instructionOut, m_ins);
        chk("PCplus4Out", PCplus4Out, m_p4);
`ifdef FETCH_PERF_EN
        chk("perf_fetched", perf_fetched, m_fetched);
        chk("perf_stall_cycles", perf_stall_cycles, m_stalls);
`endif
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        step();
        chk("rst addr", imem_addr, 32'h0);
        chk("rst valid", {31'b0, fetch_valid}, 32'h0);
        chk("wrap rst addr", addr2, 32'hFFFF_FFFC);
        reset_n = 1'b1;
        step();
        chk("first addr", imem_addr, 32'h0);
        chk("first req", {31'b0, imem_req}, 32'h1);
        chk("wrap first addr", addr2, 32'hFFFF_FFFC);
        step();
        chk("pc4 first", PCplus4Out, 32'h4);
        chk("addr 4", imem_addr, 32'h4);
        chk("wrap pc4", p42, 32'h0);
        chk("wrap valid", {31'b0, fv2}, 32'h1);
        chk("wrap next addr", addr2, 32'h0);
        step();
        chk("pc4 8", PCplus4Out, 32'h8);
        step();
        chk("pc4 12", PCplus4Out, 32'hC);
        step();
        chk("addr 0x10", imem_addr, 32'h10);
        imem_ready = 1'b0;
        repeat (3) step();
        chk("wait addr", imem_addr, 32'h10);
        chk("wait pc4", PCplus4Out, 32'h10);
        chk("wait valid", {31'b0, fetch_valid}, 32'h1);
        imem_ready = 1'b1;
        step();
        chk("wait done pc4", PCplus4Out, 32'h14);
        chk("wait done instr", instructionOut, mem(32'h10));
        stall = 1'b1;
        repeat (2) step();
        chk("stall frozen", PCplus4Out, 32'h14);
        chk("stall no req", {31'b0, imem_req}, 32'h0);
        stall = 1'b0;
        step();
        chk("skid out", instructionOut, mem(32'h14));
        chk("skid pc4", PCplus4Out, 32'h18);
        step();
        chk("after skid", PCplus4Out, 32'h1C);
        stall = 1'b1; redirect = 1'b1; redirect_target = 32'h0000_0043;
        step();
        chk("redir addr", imem_addr, 32'h40);
        chk("redir valid", {31'b0, fetch_valid}, 32'h0);
        chk("redir nop", instructionOut, 32'h0);
        redirect = 1'b0; stall = 1'b0;
        step();
        chk("redir pc4", PCplus4Out, 32'h44);
        stall = 1'b1;
        step();
        chk("hold no req", {31'b0, imem_req}, 32'h0);
        reset_n = 1'b0;
        #1;
        chk("async valid", {31'b0, fetch_valid}, 32'h0);
        chk("async addr", imem_addr, 32'h0);
        chk("async pc4", PCplus4Out, 32'h0);
        chk("async req", {31'b0, imem_req}, 32'h0);
        stall = 1'b0;
        step();
        reset_n = 1'b1;
        repeat (2) step();
        chk("post rst pc4", PCplus4Out, 32'h4);
        chk("post rst instr", instructionOut, mem(32'h0));
        for (int i = 0; i < 40; i++) begin
            imem_ready = (i % 3) != 1;
            stall = (i % 5 == 2) || (i % 5 == 3);
            redirect = (i == 25);
            redirect_target = 32'h0000_1002;
            step();
        end
        redirect = 1'b0; stall = 1'b0; imem_ready = 1'b1;
        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
